// File: rtl/ws2812_serializer_if.sv
// Frame handshake between the clock-face frame builder and the WS2812 serializer.
// The master offers a packed RGB frame and the slave accepts it with frame_ready.
interface ws2812_serializer_if #(
  parameter int NUM_LEDS = 16
);
  logic [24*NUM_LEDS-1:0] packed_rgb_data;
  logic                   frame_valid;
  logic                   frame_ready;

  modport master (
    output packed_rgb_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  packed_rgb_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/ws2812_serializer.sv
// Snapshots a packed RGB frame and shifts it out as WS2812 pulse-width-coded bits (GRB, MSB first),
// then holds the line low for the latch interval. Optional macro WS2812_BRIGHTNESS_EN adds brightness scaling.
module ws2812_serializer #(
  parameter int NUM_LEDS     = 16,
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int LATCH_CYCLES = 720
) (
  input  logic               clk,
  input  logic               reset,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]         brightness,
`endif
  ws2812_serializer_if.slave frame_if,
  output logic               data,
  output logic               busy,
  output logic               frame_done
);

  localparam int BIT_W   = $clog2(BIT_CYCLES);
  localparam int LATCH_W = $clog2(LATCH_CYCLES);
  localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [BIT_W-1:0]   T0H_LAST   = BIT_W'(T0H_CYCLES - 1);
  localparam logic [BIT_W-1:0]   T1H_LAST   = BIT_W'(T1H_CYCLES - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BIT_CYCLES - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [LED_W-1:0]   LED_LAST   = LED_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [LATCH_W-1:0]     r_latch_cnt;
  logic [LED_W-1:0]       r_led_idx;
  logic [1:0]             r_byte_idx;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic [24*NUM_LEDS-1:0] r_shadow;
  logic                   r_post_reset;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]             r_brightness;
`endif

  logic                   w_accept;
  logic                   w_high_done;
  logic                   w_low_done;
  logic                   w_byte_end;
  logic                   w_led_end;
  logic                   w_frame_end;
  logic                   w_latch_done;
  logic [LED_W-1:0]       w_led_next;
  logic [23:0]            w_load_word;
  logic [1:0]             w_load_sel;
  logic [7:0]             w_load_raw;
  logic [7:0]             w_load_byte;
  logic [7:0]             w_first_byte;
  logic [23:0]            w_led_word [NUM_LEDS];

  // Byte select within a 24'hRRGGBB word: 0=G, 1=R, 2=B (transmission order).
  function automatic logic [7:0] byte_of(input logic [23:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    return word[15:8];
      2'd1:    return word[23:16];
      default: return word[7:0];
    endcase
  endfunction

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] b, input logic [7:0] br);
    logic [15:0] w_prod;
    w_prod = {8'd0, b} * ({8'd0, br} + 16'd1);
    return w_prod[15:8];
  endfunction
`endif

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    assign w_led_word[gi] = r_shadow[24*gi +: 24];
  end

  assign w_accept     = (r_state == IDLE) && frame_if.frame_valid;
  assign w_high_done  = (r_bit_cnt == (r_shift[7] ? T1H_LAST : T0H_LAST));
  assign w_low_done   = (r_bit_cnt == BIT_LAST);
  assign w_byte_end   = (r_bit_idx == 3'd7);
  assign w_led_end    = w_byte_end && (r_byte_idx == 2'd2);
  assign w_frame_end  = w_led_end && (r_led_idx == LED_LAST);
  assign w_latch_done = (r_latch_cnt == LATCH_LAST);
  assign w_led_next   = LED_W'(r_led_idx + 1'b1);

  // The next byte comes from the following LED only after B; w_led_next is unused on the last LED.
  assign w_load_word  = (r_byte_idx == 2'd2) ? w_led_word[w_led_next] : w_led_word[r_led_idx];
  assign w_load_sel   = (r_byte_idx == 2'd2) ? 2'd0 : (r_byte_idx + 2'd1);
  assign w_load_raw   = byte_of(w_load_word, w_load_sel);

`ifdef WS2812_BRIGHTNESS_EN
  assign w_load_byte  = scale(w_load_raw, r_brightness);
  assign w_first_byte = scale(frame_if.packed_rgb_data[15:8], brightness);
`else
  assign w_load_byte  = w_load_raw;
  assign w_first_byte = frame_if.packed_rgb_data[15:8];
`endif

  always_comb begin
    w_state_next         = r_state;
    data                 = 1'b0;
    busy                 = 1'b1;
    frame_if.frame_ready = 1'b0;
    frame_done           = 1'b0;
    case (r_state)
      IDLE: begin
        busy                 = 1'b0;
        frame_if.frame_ready = 1'b1;
        if (frame_if.frame_valid) w_state_next = HIGH;
      end
      HIGH: begin
        data = 1'b1;
        if (w_high_done) w_state_next = LOW;
      end
      LOW: begin
        if (w_low_done) w_state_next = w_frame_end ? LATCH : HIGH;
      end
      LATCH: begin
        if (w_latch_done) begin
          w_state_next = IDLE;
          frame_done   = ~r_post_reset;
        end
      end
      default: w_state_next = LATCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= LATCH;
      r_bit_cnt    <= '0;
      r_latch_cnt  <= '0;
      r_led_idx    <= '0;
      r_byte_idx   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_shadow     <= '0;
      r_post_reset <= 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
      r_brightness <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shadow   <= frame_if.packed_rgb_data;
            r_shift    <= w_first_byte;
            r_led_idx  <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_bit_cnt  <= '0;
`ifdef WS2812_BRIGHTNESS_EN
            r_brightness <= brightness;
`endif
          end
        end
        HIGH: r_bit_cnt <= r_bit_cnt + 1'b1;
        LOW: begin
          if (!w_low_done) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_bit_cnt <= '0;
            if (w_frame_end) begin
              r_latch_cnt <= '0;
            end else if (w_byte_end) begin
              r_bit_idx <= '0;
              r_shift   <= w_load_byte;
              if (w_led_end) begin
                r_byte_idx <= '0;
                r_led_idx  <= w_led_next;
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {r_shift[6:0], 1'b0};
            end
          end
        end
        LATCH: begin
          if (w_latch_done) begin
            r_latch_cnt  <= '0;
            r_post_reset <= 1'b0;
          end else begin
            r_latch_cnt <= r_latch_cnt + 1'b1;
          end
        end
        default: r_latch_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer with small timing parameters; decodes the serial line
// per bit period and compares it against hand-specified frames.
module tb_ws2812_serializer;
  localparam int NL = 2;
  localparam int BC = 6;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int LC = 10;
  localparam int NB = 24 * NL;
  localparam int FC = NB * BC + LC;
  localparam logic [5:0] PAT1 = 6'b111100;
  localparam logic [5:0] PAT0 = 6'b110000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data;
  logic busy;
  logic frame_done;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] brightness = 8'hFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ws2812_serializer_if #(.NUM_LEDS(NL)) bus ();

  ws2812_serializer #(
    .NUM_LEDS     (NL),
    .BIT_CYCLES   (BC),
    .T0H_CYCLES   (T0),
    .T1H_CYCLES   (T1),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .frame_if   (bus),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected transmitted bit b of a frame: LED-major, bytes G,R,B, MSB first.
  function automatic logic exp_bit(input logic [47:0] f, input int b);
    logic [23:0] w;
    logic [7:0]  by;
    int          k;
    w = f[24*(b/24) +: 24];
    k = b % 24;
    case (k / 8)
      0:       by = w[15:8];
      1:       by = w[23:16];
      default: by = w[7:0];
    endcase
    return by[7 - (k % 8)];
  endfunction

  // Reset has just been released at a falling edge; ready must return after exactly LC rising edges.
  task automatic post_reset_check(input string name);
    int k;
    int fd;
    int dhi;
    k = 0; fd = 0; dhi = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (frame_done) fd++;
      if (data) dhi++;
      if (bus.frame_ready) break;
    end
    check_val({name, "_ready_latency"}, k, LC);
    check_val({name, "_no_frame_done"}, fd, 0);
    check_val({name, "_line_low"}, dhi, 0);
    check_val({name, "_busy_idle"}, busy, 1'b0);
    $display("reset %s: ready after %0d cycles, frame_done pulses %0d", name, k, fd);
  endtask

  // mode 0: plain; mode 1: extra frame offered during bit 5; mode 2: input changed after acceptance
  task automatic run_frame(input logic [47:0] frame, input logic [47:0] exp_f, input int mode,
                           input string name);
    logic [300:1] wv;
    logic [300:1] dn;
    logic [300:1] rd;
    logic [300:1] bs;
    logic [5:0]   pat;
    int           k;
    int           nd;
    int           pos;
    int           hi;
    int           bad;
    @(negedge clk);
    bus.packed_rgb_data = frame;
    bus.frame_valid     = 1'b1;
    k = 0;
    while (!bus.frame_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val({name, "_ready_before_accept"}, bus.frame_ready, 1'b1);
    if (!bus.frame_ready) begin
      bus.frame_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      wv[c] = data;
      dn[c] = frame_done;
      rd[c] = bus.frame_ready;
      bs[c] = busy;
      if (c == 1) begin
        bus.frame_valid = 1'b0;
        if (mode == 2) bus.packed_rgb_data = '1;
      end
      if (mode == 1 && c == 33) begin
        bus.packed_rgb_data = 48'hA5A5A5_5A5A5A;
        bus.frame_valid     = 1'b1;
        check_val({name, "_ready_while_busy"}, rd[c], 1'b0);
      end
      if (mode == 1 && c == 34) bus.frame_valid = 1'b0;
    end
    bad = 0;
    for (int b = 0; b < NB; b++) begin
      pat = '0;
      for (int j = 0; j < BC; j++) pat = {pat[4:0], wv[BC*b + 1 + j]};
      check_val($sformatf("%s_bit%0d", name, b), pat, exp_bit(exp_f, b) ? PAT1 : PAT0);
      if (pat !== (exp_bit(exp_f, b) ? PAT1 : PAT0)) bad++;
    end
    nd = 0; pos = 0; hi = 0;
    for (int c = 1; c <= 300; c++) begin
      if (dn[c]) begin
        nd++;
        pos = c;
      end
    end
    for (int c = NB*BC + 1; c <= FC; c++) if (wv[c]) hi++;
    check_val({name, "_done_count"}, nd, 1);
    check_val({name, "_done_cycle"}, pos, FC);
    check_val({name, "_latch_low"}, hi, 0);
    check_val({name, "_busy_mid"}, bs[150], 1'b1);
    check_val({name, "_ready_in_latch"}, rd[FC - 3], 1'b0);
    check_val({name, "_ready_after"}, rd[FC + 1], 1'b1);
    check_val({name, "_busy_after"}, bs[FC + 1], 1'b0);
    check_val({name, "_idle_line"}, wv[FC + 2], 1'b0);
    $display("frame %s: %0d bits, %0d bad, frame_done at cycle %0d", name, NB, bad, pos);
  endtask

  task automatic mid_frame_reset(input logic [47:0] frame);
    int k;
    @(negedge clk);
    bus.packed_rgb_data = frame;
    bus.frame_valid     = 1'b1;
    k = 0;
    while (!bus.frame_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("mr_ready_before_accept", bus.frame_ready, 1'b1);
    @(negedge clk);
    bus.frame_valid = 1'b0;
    // cycle 194 lies in the high phase of bit 32, the MSB of LED1's R byte
    repeat (193) @(negedge clk);
    check_val("mr_data_before_reset", data, 1'b1);
    reset = 1'b1;
    #1;
    check_val("mr_data_in_reset", data, 1'b0);
    check_val("mr_ready_in_reset", bus.frame_ready, 1'b0);
    check_val("mr_busy_in_reset", busy, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    post_reset_check("mr");
  endtask

  initial begin
    bus.packed_rgb_data = '0;
    bus.frame_valid     = 1'b0;
    reset               = 1'b1;
    repeat (3) @(negedge clk);
    check_val("por_data", data, 1'b0);
    check_val("por_busy", busy, 1'b1);
    check_val("por_ready", bus.frame_ready, 1'b0);
    check_val("por_done", frame_done, 1'b0);
    reset = 1'b0;
    post_reset_check("por");

    run_frame({24'h000001, 24'hFF0000}, {24'h000001, 24'hFF0000}, 0, "basic");
    run_frame({24'h000001, 24'hFF0000}, {24'h000001, 24'hFF0000}, 1, "busy");
    run_frame({24'h000001, 24'hFF0000}, {24'h000001, 24'hFF0000}, 2, "snap");
    run_frame({24'hC3A50F, 24'h3C5AF0}, {24'hC3A50F, 24'h3C5AF0}, 0, "mix");
    mid_frame_reset({24'hFF0000, 24'h123456});
    run_frame({24'h80FF01, 24'h7E0081}, {24'h80FF01, 24'h7E0081}, 0, "after_rst");
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'h7F;
    run_frame({2{24'hFFFFFF}}, {2{24'h7F7F7F}}, 0, "br7f");
    brightness = 8'hFF;
    run_frame({2{24'hFFFFFF}}, {2{24'hFFFFFF}}, 0, "brff");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
